// File: rtl/prog_loader.sv
// Boot loader: parses a MAGIC/LEN/payload/CSUM byte stream into 32-bit imem
// writes and releases the CPU from reset once a complete image checks out.
module prog_loader #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] MAGIC  = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [16:0]     CAP     = 17'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r, state_s;
  logic [15:0]         len_r, len_s;
  logic [7:0]          sum_r, sum_s;
  logic [31:0]         word_r, word_s;
  logic [1:0]          byte_cnt_r, byte_cnt_s;
  // One bit wider than the address so a full 2**ADDR_W image never wraps early
  logic [ADDR_W:0]     word_idx_r, word_idx_s;
  logic                in_ready_r, in_ready_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [31:0]         mem_wdata_r, mem_wdata_s;
  logic                cpu_reset_r, cpu_reset_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic                xfer_s;
  logic [15:0]         len_full_s;
  logic [31:0]         word_full_s;

  // Next-state and next-output logic, advancing only on an accepted byte
  always_comb begin
    xfer_s      = in_valid & in_ready_r;
    len_full_s  = {in_data, len_r[7:0]};
    word_full_s = {in_data, word_r[31:8]};
    state_s     = state_r;
    len_s       = len_r;
    sum_s       = sum_r;
    word_s      = word_r;
    byte_cnt_s  = byte_cnt_r;
    word_idx_s  = word_idx_r;
    in_ready_s  = in_ready_r;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    cpu_reset_s = cpu_reset_r;
    done_s      = done_r;
    err_s       = err_r;
    if (xfer_s) begin
      case (state_r)
        IDLE: begin
          if (in_data == MAGIC) begin
            state_s = LEN_LO;
            err_s   = 1'b0;
            sum_s   = 8'd0;
          end else begin
            state_s = IDLE;
          end
        end
        LEN_LO: begin
          len_s   = {len_r[15:8], in_data};
          state_s = LEN_HI;
        end
        LEN_HI: begin
          len_s = len_full_s;
          if ({1'b0, len_full_s} > CAP) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else if (len_full_s == 16'd0) begin
            state_s = CSUM;
          end else begin
            state_s    = DATA;
            word_idx_s = {(ADDR_W+1){1'b0}};
            byte_cnt_s = 2'd0;
          end
        end
        DATA: begin
          word_s     = word_full_s;
          sum_s      = sum_r + in_data;
          byte_cnt_s = byte_cnt_r + 2'd1;
          if (byte_cnt_r == 2'd3) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = word_idx_r[ADDR_W-1:0];
            mem_wdata_s = word_full_s;
            word_idx_s  = word_idx_r + IDX_ONE;
            if (word_idx_r == (len_r[ADDR_W:0] - IDX_ONE)) begin
              state_s = CSUM;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = DATA;
          end
        end
        CSUM: begin
          if (in_data == sum_r) begin
            state_s     = DONE;
            done_s      = 1'b1;
            cpu_reset_s = 1'b0;
            in_ready_s  = 1'b0;
          end else begin
            err_s   = 1'b1;
            state_s = IDLE;
          end
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= 16'd0;
      sum_r       <= 8'd0;
      word_r      <= 32'd0;
      byte_cnt_r  <= 2'd0;
      word_idx_r  <= {(ADDR_W+1){1'b0}};
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'd0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      sum_r       <= sum_s;
      word_r      <= word_s;
      byte_cnt_r  <= byte_cnt_s;
      word_idx_r  <= word_idx_s;
      in_ready_r  <= in_ready_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      cpu_reset_r <= cpu_reset_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
